// File: rtl/proc_issue_pkg.sv
// Shared opcodes, command record and FSM state type for the math-processor
// opcode issuer.
package proc_issue_pkg;

    localparam logic [5:0] OP_ADD    = 6'd0;
    localparam logic [5:0] OP_SUB    = 6'd1;
    localparam logic [5:0] OP_MUL    = 6'd2;
    localparam logic [5:0] OP_DIV    = 6'd3;
    localparam logic [5:0] OP_AND    = 6'd4;
    localparam logic [5:0] OP_OR     = 6'd5;
    localparam logic [5:0] OP_MREAD  = 6'd6;
    localparam logic [5:0] OP_MWRITE = 6'd7;
    localparam logic [5:0] OP_NOP    = 6'h3F;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } issue_state_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [31:0] addr;
        logic [31:0] wdata;
    } issue_cmd_t;

endpackage

// File: rtl/issue_fifo.sv
// Synchronous command FIFO with flush; no fall-through, so a pushed entry
// becomes visible at the head one cycle after the push.
module issue_fifo
    import proc_issue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  issue_cmd_t push_data,
    input  logic       pop,
    output issue_cmd_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    issue_cmd_t  mem_q [DEPTH];
    issue_cmd_t  mem_d [DEPTH];
    logic        push_en;
    logic        pop_en;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (pop_en)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (push_en && (wr_ptr_q[AW-1:0] == AW'(gi))) mem_d[gi] = push_data;
            end

            always_ff @(posedge clk) begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/proc_op_issuer.sv
// Host-side issuer: queues commands, presents each opcode to the processor for
// a single cycle with NOPs in between, and returns the sampled results.
module proc_op_issuer
    import proc_issue_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter int         ISSUE_GAP  = 1,
    parameter int         CNT_W      = 16,
    parameter logic [5:0] NOP_OPCODE = OP_NOP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [5:0]       cmd_opcode,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [5:0]       rsp_opcode,
    output logic [31:0]      rsp_result,
    output logic [31:0]      rsp_mem_data,
    output logic [CNT_W-1:0] rsp_tag,
    output logic [5:0]       proc_opcode,
    output logic [31:0]      proc_addr,
    output logic [31:0]      proc_write_data,
    input  logic [31:0]      proc_result,
    input  logic [31:0]      proc_memory_data,
    output logic             busy,
    output logic [CNT_W-1:0] issued_count
);

    localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    issue_state_t     state_q, state_d;
    logic [5:0]       proc_opcode_q, proc_opcode_d;
    logic [31:0]      proc_addr_q, proc_addr_d;
    logic [31:0]      proc_wdata_q, proc_wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [5:0]       rsp_opcode_q, rsp_opcode_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic [31:0]      rsp_mem_q, rsp_mem_d;
    logic [CNT_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [CNT_W-1:0] issued_count_q, issued_count_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    issue_cmd_t fifo_in;
    issue_cmd_t fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;

    assign fifo_in = '{opcode: cmd_opcode, addr: cmd_addr, wdata: cmd_wdata};

    issue_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (cmd_valid),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d        = state_q;
        proc_opcode_d  = proc_opcode_q;
        proc_addr_d    = proc_addr_q;
        proc_wdata_d   = proc_wdata_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_opcode_d   = rsp_opcode_q;
        rsp_result_d   = rsp_result_q;
        rsp_mem_d      = rsp_mem_q;
        rsp_tag_d      = rsp_tag_q;
        issued_count_d = issued_count_q;
        gap_cnt_d      = gap_cnt_q;
        fifo_pop       = 1'b0;

        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - {{(GAP_W-1){1'b0}}, 1'b1};
                end else if (!fifo_empty && (!rsp_valid_q || rsp_ready) && !flush) begin
                    // Only issue when the response slot is free by the time EXEC ends.
                    fifo_pop      = 1'b1;
                    proc_opcode_d = fifo_head.opcode;
                    proc_addr_d   = fifo_head.addr;
                    proc_wdata_d  = fifo_head.wdata;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d    = 1'b1;
                rsp_opcode_d   = proc_opcode_q;
                rsp_result_d   = proc_result;
                rsp_mem_d      = proc_memory_data;
                rsp_tag_d      = issued_count_q;
                issued_count_d = issued_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                proc_opcode_d  = NOP_OPCODE;
                gap_cnt_d      = GAP_W'(ISSUE_GAP - 1);
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            proc_opcode_q  <= NOP_OPCODE;
            proc_addr_q    <= '0;
            proc_wdata_q   <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_opcode_q   <= '0;
            rsp_result_q   <= '0;
            rsp_mem_q      <= '0;
            rsp_tag_q      <= '0;
            issued_count_q <= '0;
            gap_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            proc_opcode_q  <= proc_opcode_d;
            proc_addr_q    <= proc_addr_d;
            proc_wdata_q   <= proc_wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_opcode_q   <= rsp_opcode_d;
            rsp_result_q   <= rsp_result_d;
            rsp_mem_q      <= rsp_mem_d;
            rsp_tag_q      <= rsp_tag_d;
            issued_count_q <= issued_count_d;
            gap_cnt_q      <= gap_cnt_d;
        end
    end

    assign cmd_ready       = !fifo_full;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_opcode      = rsp_opcode_q;
    assign rsp_result      = rsp_result_q;
    assign rsp_mem_data    = rsp_mem_q;
    assign rsp_tag         = rsp_tag_q;
    assign proc_opcode     = proc_opcode_q;
    assign proc_addr       = proc_addr_q;
    assign proc_write_data = proc_wdata_q;
    assign issued_count    = issued_count_q;
    assign busy            = !fifo_empty || (state_q == EXEC) || rsp_valid_q;

endmodule

// File: tb/tb_proc_op_issuer.sv
// Directed bench for proc_op_issuer with a small behavioural math processor as
// the load (ADD accumulates 0x10 into reg1, OR returns addr|wdata, 16-word memory).
module tb_proc_op_issuer;
    import proc_issue_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_opcode;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [5:0]  rsp_opcode;
    logic [31:0] rsp_result;
    logic [31:0] rsp_mem_data;
    logic [15:0] rsp_tag;
    logic [5:0]  proc_opcode;
    logic [31:0] proc_addr;
    logic [31:0] proc_write_data;
    logic [31:0] proc_result;
    logic [31:0] proc_memory_data;
    logic        busy;
    logic [15:0] issued_count;

    int checks = 0;
    int errors = 0;

    proc_op_issuer #(
        .FIFO_DEPTH (8),
        .ISSUE_GAP  (1),
        .CNT_W      (16),
        .NOP_OPCODE (6'h3F)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_opcode       (cmd_opcode),
        .cmd_addr         (cmd_addr),
        .cmd_wdata        (cmd_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_opcode       (rsp_opcode),
        .rsp_result       (rsp_result),
        .rsp_mem_data     (rsp_mem_data),
        .rsp_tag          (rsp_tag),
        .proc_opcode      (proc_opcode),
        .proc_addr        (proc_addr),
        .proc_write_data  (proc_write_data),
        .proc_result      (proc_result),
        .proc_memory_data (proc_memory_data),
        .busy             (busy),
        .issued_count     (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Processor load model
    logic [31:0] reg1;
    logic [31:0] pmem [16];

    always_comb begin
        case (proc_opcode)
            OP_ADD:  proc_result = reg1 + 32'h10;
            OP_OR:   proc_result = proc_addr | proc_write_data;
            default: proc_result = 32'h0;
        endcase
    end
    assign proc_memory_data = pmem[proc_addr[3:0]];

    always @(posedge clk) begin
        if (!reset) begin
            reg1 <= 32'h0;
            for (int i = 0; i < 16; i++) pmem[i] <= 32'h0;
        end else begin
            if (proc_opcode == OP_ADD) reg1 <= reg1 + 32'h10;
            if (proc_opcode == OP_MWRITE) pmem[proc_addr[3:0]] <= proc_write_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        flush     = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    typedef struct {
        logic        vld;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [5:0]  e_pop;
        logic        e_rv;
        logic        e_busy;
        logic [15:0] e_cnt;
        logic        chk_rsp;
        logic [5:0]  e_rop;
        logic [31:0] e_res;
        logic [31:0] e_mem;
        logic [15:0] e_tag;
    } vec_t;

    function automatic vec_t mk(logic vld, logic [5:0] op, logic [31:0] addr, logic [31:0] wdata,
                                logic [5:0] e_pop, logic e_rv, logic e_busy, logic [15:0] e_cnt,
                                logic chk_rsp, logic [5:0] e_rop, logic [31:0] e_res,
                                logic [31:0] e_mem, logic [15:0] e_tag);
        vec_t v;
        v.vld = vld; v.op = op; v.addr = addr; v.wdata = wdata;
        v.e_pop = e_pop; v.e_rv = e_rv; v.e_busy = e_busy; v.e_cnt = e_cnt;
        v.chk_rsp = chk_rsp; v.e_rop = e_rop; v.e_res = e_res; v.e_mem = e_mem; v.e_tag = e_tag;
        return v;
    endfunction

    function automatic logic [31:0] or_res(int k);
        return 32'(k + 1) | (32'(k) << 8);
    endfunction

    vec_t vecs [11];

    initial begin
        int n;
        int k;
        int last_exec;
        int nr;
        int ne;
        logic acc;

        flush      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = 6'h0;
        cmd_addr   = 32'h0;
        cmd_wdata  = 32'h0;
        rsp_ready  = 1'b1;

        // Per-cycle vectors: inputs, then expected outputs seen in that same cycle
        vecs[0]  = mk(1, OP_ADD,    0, 0,            6'h3F, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, OP_NOP,    0, 0,            6'h3F, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, OP_NOP,    0, 0,            OP_ADD, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, OP_NOP,    0, 0,            6'h3F, 1, 1, 1, 1, OP_ADD, 32'h10, 0, 0);
        vecs[4]  = mk(1, OP_MWRITE, 5, 32'hDEADBEEF, 6'h3F, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, OP_MREAD,  5, 0,            6'h3F, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, OP_NOP,    0, 0,            OP_MWRITE, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, OP_NOP,    0, 0,            6'h3F, 1, 1, 2, 1, OP_MWRITE, 0, 0, 1);
        vecs[8]  = mk(0, OP_NOP,    0, 0,            OP_MREAD, 0, 1, 2, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, OP_NOP,    0, 0,            6'h3F, 1, 1, 3, 1, OP_MREAD, 0, 32'hDEADBEEF, 2);
        vecs[10] = mk(0, OP_NOP,    0, 0,            6'h3F, 0, 0, 3, 0, 0, 0, 0, 0);

        // 1. reset state, checked while reset is still held
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_proc_opcode", 64'(proc_opcode), 64'h3F);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_issued_count", 64'(issued_count), 64'h0);
        chk("rst_proc_addr", 64'(proc_addr), 64'h0);
        reset = 1'b1;
        tick();

        // 2+3. single ADD, then MWRITE followed by MREAD
        for (int i = 0; i < 11; i++) begin
            cmd_valid  = vecs[i].vld;
            cmd_opcode = vecs[i].op;
            cmd_addr   = vecs[i].addr;
            cmd_wdata  = vecs[i].wdata;
            $display("vec %0d: proc_opcode=%0h rsp_valid=%0d busy=%0d cnt=%0d", i, proc_opcode,
                     rsp_valid, busy, issued_count);
            chk($sformatf("v%0d_proc_opcode", i), 64'(proc_opcode), 64'(vecs[i].e_pop));
            chk($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].e_rv));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
            chk($sformatf("v%0d_issued_count", i), 64'(issued_count), 64'(vecs[i].e_cnt));
            if (vecs[i].chk_rsp) begin
                chk($sformatf("v%0d_rsp_opcode", i), 64'(rsp_opcode), 64'(vecs[i].e_rop));
                chk($sformatf("v%0d_rsp_result", i), 64'(rsp_result), 64'(vecs[i].e_res));
                chk($sformatf("v%0d_rsp_mem_data", i), 64'(rsp_mem_data), 64'(vecs[i].e_mem));
                chk($sformatf("v%0d_rsp_tag", i), 64'(rsp_tag), 64'(vecs[i].e_tag));
            end
            tick();
        end
        chk("idle_proc_addr_kept", 64'(proc_addr), 64'h5);

        // 4. back-pressure: fill FIFO while the response is stalled, then drain
        do_reset();
        rsp_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 16; c++) begin
            if (n < 12) begin
                cmd_valid  = 1'b1;
                cmd_opcode = OP_OR;
                cmd_addr   = 32'(n + 1);
                cmd_wdata  = 32'(n) << 8;
            end else begin
                cmd_valid = 1'b0;
            end
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) n++;
        end
        cmd_valid = 1'b0;
        $display("backpressure: accepted=%0d cmd_ready=%0d", n, cmd_ready);
        chk("bp_accepted", 64'(n), 64'd9);
        chk("bp_cmd_ready", 64'(cmd_ready), 64'h0);
        chk("bp_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("bp_rsp_tag_stable", 64'(rsp_tag), 64'h0);
        chk("bp_rsp_result_stable", 64'(rsp_result), 64'(or_res(0)));
        chk("bp_issued_count", 64'(issued_count), 64'h1);

        rsp_ready = 1'b1;
        k = 0;
        last_exec = -10;
        for (int c = 0; c < 100 && k < 9; c++) begin
            if (proc_opcode != 6'h3F) begin
                chk("drain_exec_gap", 64'((c - last_exec) >= 2), 64'h1);
                last_exec = c;
            end
            if (rsp_valid) begin
                $display("rsp: tag=%0d opcode=%0h result=%0h", rsp_tag, rsp_opcode, rsp_result);
                chk("drain_tag", 64'(rsp_tag), 64'(k));
                chk("drain_result", 64'(rsp_result), 64'(or_res(k)));
                chk("drain_opcode", 64'(rsp_opcode), 64'(OP_OR));
                k++;
            end
            tick();
        end
        chk("drain_count", 64'(k), 64'd9);
        tick();
        tick();
        chk("drain_busy", 64'(busy), 64'h0);
        chk("drain_issued_count", 64'(issued_count), 64'd9);
        chk("drain_rsp_valid", 64'(rsp_valid), 64'h0);

        // 5. reset during EXEC with another command queued
        do_reset();
        cmd_valid  = 1'b1;
        cmd_opcode = OP_ADD;
        cmd_addr   = 32'h0;
        cmd_wdata  = 32'h0;
        tick();
        cmd_opcode = OP_OR;
        cmd_addr   = 32'h3;
        cmd_wdata  = 32'h4;
        tick();
        cmd_valid = 1'b0;
        chk("rx_exec_opcode", 64'(proc_opcode), 64'(OP_ADD));
        reset = 1'b0;
        tick();
        $display("reset-in-exec: proc_opcode=%0h rsp_valid=%0d busy=%0d", proc_opcode, rsp_valid, busy);
        chk("rx_proc_opcode", 64'(proc_opcode), 64'h3F);
        chk("rx_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rx_busy", 64'(busy), 64'h0);
        chk("rx_issued_count", 64'(issued_count), 64'h0);
        reset = 1'b1;
        nr = 0;
        ne = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (rsp_valid) nr++;
            if (proc_opcode != 6'h3F) ne++;
        end
        chk("rx_no_rsp", 64'(nr), 64'h0);
        chk("rx_no_exec", 64'(ne), 64'h0);

        // 6. flush during EXEC of the first of three commands
        do_reset();
        cmd_valid  = 1'b1;
        cmd_opcode = OP_OR;
        cmd_addr   = 32'h1;
        cmd_wdata  = 32'h10;
        tick();
        cmd_addr  = 32'h2;
        cmd_wdata = 32'h20;
        tick();
        cmd_addr  = 32'h3;
        cmd_wdata = 32'h30;
        flush     = 1'b1;
        chk("fl_exec_opcode", 64'(proc_opcode), 64'(OP_OR));
        tick();
        cmd_valid = 1'b0;
        flush     = 1'b0;
        $display("flush: rsp_valid=%0d tag=%0d result=%0h", rsp_valid, rsp_tag, rsp_result);
        chk("fl_rsp_tag", 64'(rsp_tag), 64'h0);
        chk("fl_rsp_result", 64'(rsp_result), 64'h11);
        chk("fl_busy_rsp", 64'(busy), 64'h1);
        nr = 0;
        ne = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid) nr++;
            if (proc_opcode != 6'h3F) ne++;
            if (c == 1) chk("fl_busy_after", 64'(busy), 64'h0);
            tick();
        end
        chk("fl_rsp_count", 64'(nr), 64'h1);
        chk("fl_exec_count", 64'(ne), 64'h0);
        chk("fl_issued_count", 64'(issued_count), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
